// File: rtl/bfly_2_2_stage.sv
// Forward butterfly stage with run-time double-buffered per-mode swap controls
// and an optional one-deep output register on a valid/ready stream.
module bfly_2_2_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int MODE_WIDTH  = 2,
  parameter int STAGE_ORDER = 0,
  parameter bit IS_PIPED    = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_WIDTH+MODE_WIDTH-1:0] din_mod,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic [DATA_WIDTH+MODE_WIDTH-1:0] dout,
  output logic                             m_valid,
  input  logic                             m_ready,
  input  logic                             cfg_wr_en,
  input  logic [MODE_WIDTH-1:0]            cfg_mode,
  input  logic [DATA_WIDTH/2-1:0]          cfg_data,
  input  logic                             cfg_commit,
  output logic                             cfg_pending
);

  localparam int SHIFT      = 1 << STAGE_ORDER;
  localparam int HALF       = DATA_WIDTH / 2;
  localparam int REGION_NUM = HALF / SHIFT;
  localparam int E          = DATA_WIDTH / REGION_NUM;
  localparam int NMODE      = 1 << MODE_WIDTH;
  localparam int DW         = DATA_WIDTH + MODE_WIDTH;

  typedef logic [HALF-1:0] ctrl_t;

  ctrl_t shadow_q [NMODE];
  ctrl_t shadow_d [NMODE];
  ctrl_t active_q [NMODE];
  ctrl_t active_d [NMODE];
  logic  pending_q;
  logic  pending_d;

  logic [MODE_WIDTH-1:0] mode;
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] perm;
  ctrl_t                 ctrl;

  assign mode = din_mod[MODE_WIDTH-1:0];
  assign data = din_mod[DW-1:MODE_WIDTH];
  assign ctrl = active_q[mode];

  for (genvar i = 0; i < REGION_NUM; i++) begin : g_region
    for (genvar j = 0; j < E/2; j++) begin : g_pair
      localparam int A = E*i + j;
      localparam int B = A + SHIFT;
      localparam int K = i*(E/2) + j;
      assign perm[A] = ctrl[K] ? data[B] : data[A];
      assign perm[B] = ctrl[K] ? data[A] : data[B];
    end
  end

  // Commit copies the pre-write shadow; a same-cycle write stays pending.
  always_comb begin
    for (int m = 0; m < NMODE; m++) begin
      shadow_d[m] = shadow_q[m];
      active_d[m] = active_q[m];
    end
    pending_d = pending_q;
    if (cfg_commit) begin
      for (int m = 0; m < NMODE; m++) begin
        active_d[m] = shadow_q[m];
      end
      pending_d = 1'b0;
    end
    if (cfg_wr_en) begin
      shadow_d[cfg_mode] = cfg_data;
      pending_d          = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < NMODE; m++) begin
        shadow_q[m] <= '0;
        active_q[m] <= '0;
      end
      pending_q <= 1'b0;
    end else begin
      for (int m = 0; m < NMODE; m++) begin
        shadow_q[m] <= shadow_d[m];
        active_q[m] <= active_d[m];
      end
      pending_q <= pending_d;
    end
  end

  assign cfg_pending = pending_q;

  if (IS_PIPED) begin : g_piped
    logic [DW-1:0] dout_q;
    logic [DW-1:0] dout_d;
    logic          valid_q;
    logic          valid_d;
    logic          accept;

    assign s_ready = !valid_q || m_ready;
    assign accept  = s_valid && s_ready;

    always_comb begin
      dout_d  = dout_q;
      valid_d = valid_q;
      if (accept) begin
        dout_d  = {perm, mode};
        valid_d = 1'b1;
      end else if (m_ready) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        dout_q  <= dout_d;
        valid_q <= valid_d;
      end
    end

    assign dout    = dout_q;
    assign m_valid = valid_q;
  end else begin : g_comb
    assign dout    = {perm, mode};
    assign m_valid = s_valid;
    assign s_ready = m_ready;
  end

endmodule

// File: tb/tb_bfly_2_2_stage.sv
// Bench for bfly_2_2_stage: piped order-0, piped order-2 and unpiped order-1
// instances share one stimulus and are checked against a behavioural model.
module tb_bfly_2_2_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] din_mod;
  logic       s_valid;
  logic       m_ready;
  logic       cfg_wr_en;
  logic [1:0] cfg_mode;
  logic [3:0] cfg_data;
  logic       cfg_commit;

  logic [9:0] dout0, dout2, doutu;
  logic       m_valid0, m_valid2, m_validu;
  logic       s_ready0, s_ready2, s_readyu;
  logic       pend0, pend2, pendu;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  bfly_2_2_stage #(.DATA_WIDTH(8), .MODE_WIDTH(2), .STAGE_ORDER(0), .IS_PIPED(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .din_mod(din_mod), .s_valid(s_valid),
    .s_ready(s_ready0), .dout(dout0), .m_valid(m_valid0), .m_ready(m_ready),
    .cfg_wr_en(cfg_wr_en), .cfg_mode(cfg_mode), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_pending(pend0));

  bfly_2_2_stage #(.DATA_WIDTH(8), .MODE_WIDTH(2), .STAGE_ORDER(2), .IS_PIPED(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .din_mod(din_mod), .s_valid(s_valid),
    .s_ready(s_ready2), .dout(dout2), .m_valid(m_valid2), .m_ready(m_ready),
    .cfg_wr_en(cfg_wr_en), .cfg_mode(cfg_mode), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_pending(pend2));

  bfly_2_2_stage #(.DATA_WIDTH(8), .MODE_WIDTH(2), .STAGE_ORDER(1), .IS_PIPED(1'b0)) uu (
    .clk(clk), .rst_n(rst_n), .din_mod(din_mod), .s_valid(s_valid),
    .s_ready(s_readyu), .dout(doutu), .m_valid(m_validu), .m_ready(m_ready),
    .cfg_wr_en(cfg_wr_en), .cfg_mode(cfg_mode), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_pending(pendu));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Pair p lives in region p/shift at offset p%shift and is steered by ctrl bit p.
  function automatic logic [7:0] ref_perm(input logic [7:0] d, input logic [3:0] c,
                                          input int shift);
    logic [7:0] r;
    r = d;
    for (int p = 0; p < 4; p++) begin
      int a;
      int b;
      a = (p / shift) * 2 * shift + (p % shift);
      b = a + shift;
      if (c[p]) begin
        r[a] = d[b];
        r[b] = d[a];
      end
    end
    return r;
  endfunction

  logic       mv;
  logic [9:0] md0, md2;
  logic [3:0] act [4];
  logic [3:0] shd [4];
  logic       pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv = 1'b0; md0 = '0; md2 = '0; pend = 1'b0;
      for (int m = 0; m < 4; m++) begin
        act[m] = '0;
        shd[m] = '0;
      end
    end else begin
      if (s_valid && (!mv || m_ready)) begin
        mv  = 1'b1;
        md0 = {ref_perm(din_mod[9:2], act[din_mod[1:0]], 1), din_mod[1:0]};
        md2 = {ref_perm(din_mod[9:2], act[din_mod[1:0]], 4), din_mod[1:0]};
      end else if (m_ready) begin
        mv = 1'b0;
      end
      if (cfg_commit) act = shd;
      if (cfg_wr_en) shd[cfg_mode] = cfg_data;
      if (cfg_wr_en) pend = 1'b1;
      else if (cfg_commit) pend = 1'b0;
    end
  end

  logic [9:0] dq [$];
  always @(posedge clk) begin
    if (rst_n && m_valid0 && m_ready) dq.push_back(dout0);
  end

  always @(negedge clk) begin
    #1;
    if (cmp_en && rst_n) begin
      chk("p0_valid", 32'(m_valid0), 32'(mv));
      if (mv) chk("p0_dout", 32'(dout0), 32'(md0));
      chk("p0_ready", 32'(s_ready0), 32'(!mv || m_ready));
      chk("p0_pending", 32'(pend0), 32'(pend));
      chk("p2_valid", 32'(m_valid2), 32'(mv));
      if (mv) chk("p2_dout", 32'(dout2), 32'(md2));
      chk("p2_pending", 32'(pend2), 32'(pend));
      chk("u_valid", 32'(m_validu), 32'(s_valid));
      chk("u_ready", 32'(s_readyu), 32'(m_ready));
      chk("u_pending", 32'(pendu), 32'(pend));
      if (s_valid)
        chk("u_dout", 32'(doutu),
            32'({ref_perm(din_mod[9:2], act[din_mod[1:0]], 2), din_mod[1:0]}));
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] m,
                       input logic mr, input logic we, input logic [1:0] wm,
                       input logic [3:0] wd, input logic cm);
    s_valid = v; din_mod = {d, m}; m_ready = mr;
    cfg_wr_en = we; cfg_mode = wm; cfg_data = wd; cfg_commit = cm;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    s_valid = 1'b0; din_mod = '0; m_ready = 1'b0;
    cfg_wr_en = 1'b0; cfg_mode = '0; cfg_data = '0; cfg_commit = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    chk("rst_dout", 32'(dout0), 32'h0);
    chk("rst_valid", 32'(m_valid0), 32'h0);
    chk("rst_ready", 32'(s_ready0), 32'h1);
    chk("rst_pending", 32'(pend0), 32'h0);

    for (int m = 0; m < 4; m++) begin
      drive(1'b1, 8'hA5, 2'(m), 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
      chk("ident_valid", 32'(m_valid0), 32'h1);
      chk("ident_dout", 32'(dout0), 32'({8'hA5, 2'(m)}));
    end

    drive(1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 2'd1, 4'b0001, 1'b0);
    chk("wr_pending", 32'(pend0), 32'h1);
    drive(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1);
    chk("commit_pending", 32'(pend0), 32'h0);
    drive(1'b1, 8'h02, 2'd1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
    chk("swap_m1", 32'(dout0), 32'({8'h01, 2'd1}));
    drive(1'b1, 8'h02, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
    chk("swap_m0", 32'(dout0), 32'({8'h02, 2'd0}));

    drive(1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 2'd2, 4'b1111, 1'b0);
    drive(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1);
    drive(1'b1, 8'h0F, 2'd2, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
    chk("so2_ffff", 32'(dout2), 32'({8'hF0, 2'd2}));
    drive(1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 2'd2, 4'b0101, 1'b0);
    drive(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1);
    drive(1'b1, 8'h0F, 2'd2, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
    chk("so2_0101", 32'(dout2), 32'({8'h5A, 2'd2}));

    drive(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
    dq.delete();
    drive(1'b1, 8'h33, 2'd0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
    chk("bp_first", 32'(dout0), 32'({8'h33, 2'd0}));
    chk("bp_sready", 32'(s_ready0), 32'h0);
    drive(1'b1, 8'h44, 2'd0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
    chk("bp_hold", 32'(dout0), 32'({8'h33, 2'd0}));
    drive(1'b1, 8'h44, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
    chk("bp_second", 32'(dout0), 32'({8'h44, 2'd0}));
    drive(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
    chk("bp_count", 32'(dq.size()), 32'd2);
    if (dq.size() == 2) begin
      chk("bp_order0", 32'(dq[0]), 32'({8'h33, 2'd0}));
      chk("bp_order1", 32'(dq[1]), 32'({8'h44, 2'd0}));
    end

    drive(1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 2'd1, 4'h0, 1'b0);
    drive(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1);
    drive(1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 2'd1, 4'hF, 1'b0);
    drive(1'b1, 8'h01, 2'd1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1);
    chk("coll_old", 32'(dout0), 32'({8'h01, 2'd1}));
    drive(1'b1, 8'h01, 2'd1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
    chk("coll_new", 32'(dout0), 32'({8'h02, 2'd1}));
    drive(1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 2'd3, 4'h1, 1'b1);
    chk("wr_commit_pending", 32'(pend0), 32'h1);

    drive(1'b1, 8'h02, 2'd1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
    chk("pre_rst_valid", 32'(m_valid0), 32'h1);
    chk("pre_rst_dout", 32'(dout0), 32'({8'h01, 2'd1}));
    #3 rst_n = 1'b0;
    #1;
    chk("async_valid0", 32'(m_valid0), 32'h0);
    chk("async_valid2", 32'(m_valid2), 32'h0);
    chk("async_pending", 32'(pend0), 32'h0);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b1;
    drive(1'b1, 8'h02, 2'd1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
    chk("post_rst_ident", 32'(dout0), 32'({8'h02, 2'd1}));

    for (int c = 0; c < 1500; c++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom),
            $urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0, 2'($urandom),
            4'($urandom), $urandom_range(0, 7) == 0);
    end
    drive(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
    drive(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bfly_2_2_stage.md
# bfly_2_2_stage

One stage of the forward butterfly (BFLY) permutation network. It undoes the swap pattern of the inverse-butterfly stage with the same `STAGE_ORDER`. Unlike the static-INIT inverse stages, its per-mode swap controls are loaded at run time through a double-buffered config port. Data moves on a valid/ready stream, with optional one-register pipelining and backpressure, so stages can be chained into a full BFLY network on the parser's extract/reorder path.

## Interface
Parameters:
- `DATA_WIDTH`, 32, permuted data width; power of two, ≥ 2·SHIFT
- `MODE_WIDTH`, 2, mode tag width; selects one of 2^MODE_WIDTH control words
- `STAGE_ORDER`, 0, stage index; SHIFT = 2^STAGE_ORDER
- `IS_PIPED`, 1, 1 = registered output stage, 0 = combinational pass-through

Ports:
- `clk`  in  1  clock; one clock domain
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `din_mod`  in  DATA_WIDTH+MODE_WIDTH  {data, mode}; mode is in the low MODE_WIDTH bits
- `s_valid`  in  1  input beat valid
- `s_ready`  out  1  stage can accept a beat
- `dout`  out  DATA_WIDTH+MODE_WIDTH  {permuted data, mode passed through unchanged}
- `m_valid`  out  1  output beat valid
- `m_ready`  in  1  downstream accepts
- `cfg_wr_en`  in  1  write one shadow control word
- `cfg_mode`  in  MODE_WIDTH  shadow entry index
- `cfg_data`  in  DATA_WIDTH/2  control bits for that mode
- `cfg_commit`  in  1  copy the whole shadow table to the active table
- `cfg_pending`  out  1  shadow differs from active (a write has occurred since the last commit)

## Operation
- Constants: REGION_NUM = (DATA_WIDTH/2)/SHIFT, E = DATA_WIDTH/REGION_NUM.
- For region i in [0, REGION_NUM) and j in [0, E/2):
  - pair is a = E·i+j, b = a+SHIFT;
  - control bit index k = i·(E/2)+j;
  - c = active[mode][k].
  - If c = 0, out[a]=din[a] and out[b]=din[b]. If c = 1, out[a]=din[b] and out[b]=din[a].
- Tables: the shadow and active tables each hold 2^MODE_WIDTH × DATA_WIDTH/2 flops. Reset clears both to all zeros, so every mode is the identity.
- `cfg_wr_en`: `shadow[cfg_mode] <= cfg_data`; sets `cfg_pending`.
- `cfg_commit`: `active <= shadow` as it stood before this cycle's write; clears `cfg_pending`.
- Write and commit in the same cycle: the commit copies the old shadow, the write lands in shadow, and `cfg_pending` ends at 1.
- A beat is permuted with the active table sampled in its accept cycle (`s_valid && s_ready`). A commit in that same cycle affects only later beats.
- `IS_PIPED`=1:
  - Output register with `s_ready = !m_valid || m_ready`.
  - On accept, `dout`/`m_valid` load next edge.
  - `m_valid` clears when `m_ready` is high and there is no new accept.
  - `dout` holds stable while `m_valid && !m_ready`.
- `IS_PIPED`=0:
  - `dout` is the combinational permutation of `din_mod`.
  - `m_valid = s_valid`, `s_ready = m_ready`.
- The mode field is never altered. Out-of-range modes do not exist because the table is fully sized.

## Timing
- Reset values (`rst_n` low, asynchronous):
  - `m_valid` = 0;
  - `dout` = 0 (when piped);
  - `cfg_pending` = 0;
  - both tables = 0;
  - `s_ready` = 1 (when piped).
- Latency:
  - piped: 1 cycle from accept to `m_valid`;
  - unpiped: 0 cycles.
- Throughput: 1 beat per cycle when `m_ready` is held high.
- Commit-to-effect: a beat accepted the cycle after `cfg_commit` uses the new table.
- Reset mid-stream: any in-flight beat is dropped, and the tables return to the identity.

## Test plan
Piped cases use `DATA_WIDTH`=8, `MODE_WIDTH`=2, `STAGE_ORDER`=0 (pairs (0,1),(2,3),(4,5),(6,7)) unless noted.
- Reset identity: after reset, send data 8'hA5 with mode 0. Required: one cycle later `m_valid`=1, data 8'hA5, mode 0. Repeat for modes 1–3 with the same result.
- Configured swap:
  - Write mode 1 with ctrl 4'b0001. Required: `cfg_pending`=1.
  - Commit. Required: `cfg_pending`=0.
  - Send 8'h02 with mode 1. Required: data 8'h01, mode 1.
  - Send 8'h02 with mode 0. Required: data 8'h02.
- `STAGE_ORDER`=2 variant (pairs (j, j+4)):
  - Mode 2 with ctrl 4'b1111, send 8'h0F. Required: 8'hF0.
  - Ctrl 4'b0101, send 8'h0F. Required: 8'h5A.
- Backpressure:
  - Hold `m_ready`=0 and send 8'h33 then 8'h44. Required: `s_ready`=0 after the first beat; `dout` holds 8'h33 unchanged.
  - Raise `m_ready`. Required: 8'h33 then 8'h44 delivered in order, no loss or duplication.
- Commit/accept collision:
  - Active mode 1 = 0, shadow mode 1 = 4'hF.
  - Commit in the same cycle as accepting 8'h01 with mode 1. Required: output 8'h01.
  - Next beat 8'h01. Required: output 8'h02.
  - Write and commit in the same cycle. Required: `cfg_pending`=1 afterwards.
- Async reset mid-operation:
  - Assert `rst_n` low while `m_valid`=1 with a non-identity table active.
  - Required: `m_valid` drops immediately, without waiting for a clock edge.
  - After release, 8'h02 with mode 1 returns 8'h02 (identity).
